if_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the `instr_rom` on behalf of the pipeline. It owns the fetch PC, issues word-aligned read requests to the ROM under a credit scheme, and buffers returned instructions with their PCs in a small in-order FIFO for the decode stage. It also handles branch/jump redirects, including squashing in-flight ROM responses, so decode only ever sees instructions on the correct path.

---
 rtl/if_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_if_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues credit-limited ROM reads
// and buffers returned {pc, instr} pairs in an in-order FIFO for decode.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = `PC_RESET,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_if_valid,
  input  logic        i_id_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_inflight, r_kill, r_count;
  logic [PW-1:0] r_wptr, r_rptr, r_qwptr, r_qrptr;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_iq_pc     [DEPTH];

  logic          w_pop, w_rsp, w_drop, w_push, w_issue;
  logic [CW:0]   w_used;
  logic [1:0]    w_unused_lsb;

  assign w_unused_lsb = i_redirect_pc[1:0];

  // Redirect squashes the head combinationally so decode never pops a wrong-path entry.
  assign o_if_valid = (r_count != '0) & ~i_redirect;
  assign o_if_instr = r_instr_mem[r_rptr];
  assign o_if_pc    = r_pc_mem[r_rptr];
  assign w_pop      = o_if_valid & i_id_ready;

  assign w_rsp  = i_mem_valid & (r_inflight != '0);
  assign w_drop = w_rsp & (i_redirect | (r_kill != '0));
  assign w_push = w_rsp & ~w_drop;

  // Credit counts buffered entries plus every outstanding read, killed ones included.
  assign w_used      = {1'b0, r_count} + {1'b0, r_inflight} - (CW+1)'(w_pop);
  assign w_issue     = rst_n & ~i_redirect & (w_used < LIM);
  assign o_mem_ready = w_issue;
  assign o_mem_addr  = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_kill     <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_qwptr    <= '0;
      r_qrptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= '0;
        r_iq_pc[i]     <= '0;
      end
    end else begin
      if (w_issue) begin
        r_pc             <= r_pc + 32'd4;
        r_iq_pc[r_qwptr] <= r_pc;
        r_qwptr          <= r_qwptr + PW'(1);
      end
      if (w_rsp) r_qrptr <= r_qrptr + PW'(1);

      case ({w_issue, w_rsp})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (i_redirect) begin
        r_pc    <= {i_redirect_pc[31:2], 2'b00};
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_kill  <= r_inflight - CW'(w_rsp);
      end else begin
        if (w_rsp && (r_kill != '0)) r_kill <= r_kill - CW'(1);
        if (w_push) begin
          r_instr_mem[r_wptr] <= i_mem_rdata;
          r_pc_mem[r_wptr]    <= r_iq_pc[r_qrptr];
          r_wptr              <= r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: in-order ROM model with variable latency, a scoreboard of
// expected {pc, instr} per issue, a hand-derived stream/stall table and directed corners.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int          DP     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic [31:0] o_mem_addr;
  logic        o_mem_ready;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_valid = 1'b0;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        o_if_valid;
  logic        i_id_ready = 1'b1;

  if_fetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_mem_addr(o_mem_addr), .o_mem_ready(o_mem_ready), .i_mem_rdata(i_mem_rdata),
    .i_mem_valid(i_mem_valid), .o_if_instr(o_if_instr), .o_if_pc(o_if_pc),
    .o_if_valid(o_if_valid), .i_id_ready(i_id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int id; bit dead; } rom_t;
  typedef struct { logic [31:0] pc; int vis; int id; } exp_t;
  typedef struct { bit idr; bit rdy; logic [31:0] addr; bit vld; logic [31:0] pc; } vec_t;

  rom_t        pend[$];
  exp_t        expq[$];
  vec_t        tbl[18];
  int          tests = 0, fails = 0;
  int          cyc = 0, lat = 1, nid = 0;
  bit          rel_pending = 0, stale_pending = 0;
  logic [31:0] exp_fpc = RST_PC;
  logic        s_rdy, s_vld;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_mem_ready", 32'(o_mem_ready), 0);
    chk("rst_mem_addr", o_mem_addr, RST_PC);
    chk("rst_if_valid", 32'(o_if_valid), 0);
    chk("rst_if_instr", o_if_instr, 0);
    chk("rst_if_pc", o_if_pc, 0);
  endtask

  task automatic do_reset(input bit stale);
    @(negedge clk);
    rst_n = 1'b0; i_redirect = 1'b0; i_mem_valid = 1'b0; i_id_ready = 1'b1;
    #1 chk_reset_vals();
    pend.delete(); expq.delete(); exp_fpc = RST_PC;
    @(negedge clk); @(negedge clk);
    #1 chk_reset_vals();
    rel_pending = 1; stale_pending = stale; cyc = 0;
  endtask

  // One cycle: drive at negedge, sample 1ns later, compare against the model, advance it.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit idr);
    bit rsp_hit, exp_vld, pop;
    int occ;
    @(negedge clk);
    if (rel_pending) begin rst_n = 1'b1; rel_pending = 0; end
    i_redirect = redir; i_redirect_pc = rpc; i_id_ready = idr;
    rsp_hit = (pend.size() > 0) && (pend[0].due <= cyc);
    if (rsp_hit) begin
      i_mem_valid = 1'b1; i_mem_rdata = rom(pend[0].addr);
    end else if (stale_pending) begin
      i_mem_valid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF; stale_pending = 0;
    end else begin
      i_mem_valid = 1'b0; i_mem_rdata = $urandom;
    end
    #1;
    s_rdy = o_mem_ready; s_addr = o_mem_addr; s_vld = o_if_valid;
    s_pc = o_if_pc; s_instr = o_if_instr;

    occ = expq.size();
    foreach (pend[i]) if (pend[i].dead) occ++;
    exp_vld = !redir && (expq.size() > 0) && (expq[0].vis <= cyc);
    pop = exp_vld && idr;
    chk("mem_ready", 32'(s_rdy), 32'(!redir && ((occ - int'(pop)) < DP)));
    chk("mem_addr", s_addr, exp_fpc);
    chk("if_valid", 32'(s_vld), 32'(exp_vld));
    if (exp_vld && s_vld) begin
      chk("if_pc", s_pc, expq[0].pc);
      chk("if_instr", s_instr, rom(expq[0].pc));
    end

    if (rsp_hit) begin
      if (!pend[0].dead)
        foreach (expq[i]) if (expq[i].id == pend[0].id) expq[i].vis = cyc + 1;
      void'(pend.pop_front());
    end
    if (pop && expq.size() > 0) void'(expq.pop_front());
    if (redir) begin
      expq.delete();
      foreach (pend[i]) pend[i].dead = 1;
      exp_fpc = {rpc[31:2], 2'b00};
    end else if (s_rdy) begin
      pend.push_back('{s_addr, cyc + lat, nid, 1'b0});
      expq.push_back('{exp_fpc, 1 << 30, nid});
      nid++;
      exp_fpc = exp_fpc + 32'd4;
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit idr);
    for (int i = 0; i < n; i++) step(1'b0, '0, idr);
  endtask

  initial begin
    int bad200;
    // Stream, then 6-cycle decode stall, then release (RESET_PC = 0x1000, 1-cycle ROM).
    for (int k = 0; k < 8; k++) tbl[k] = '{1'b1, 1'b1, RST_PC + 32'(4*k), k >= 2, RST_PC + 32'(4*(k-2))};
    for (int k = 8; k < 14; k++) tbl[k] = '{1'b0, 1'b0, RST_PC + 32'h20, 1'b1, RST_PC + 32'h18};
    tbl[14] = '{1'b1, 1'b1, RST_PC + 32'h20, 1'b1, RST_PC + 32'h18};
    tbl[15] = '{1'b1, 1'b1, RST_PC + 32'h24, 1'b1, RST_PC + 32'h1C};
    tbl[16] = '{1'b1, 1'b1, RST_PC + 32'h28, 1'b1, RST_PC + 32'h20};
    tbl[17] = '{1'b1, 1'b1, RST_PC + 32'h2C, 1'b1, RST_PC + 32'h24};

    do_reset(1'b0);
    for (int k = 0; k < 18; k++) begin
      step(1'b0, '0, tbl[k].idr);
      chk("tbl_ready", 32'(s_rdy), 32'(tbl[k].rdy));
      chk("tbl_addr", s_addr, tbl[k].addr);
      chk("tbl_valid", 32'(s_vld), 32'(tbl[k].vld));
      if (tbl[k].vld) chk("tbl_pc", s_pc, tbl[k].pc);
    end

    // Redirect with one entry buffered and one read in flight.
    step(1'b1, 32'h0000_0100, 1'b1);
    chk("redir_squash_valid", 32'(s_vld), 0);
    chk("redir_no_issue", 32'(s_rdy), 0);
    step(1'b0, '0, 1'b1);
    chk("redir_issue_addr", s_addr, 32'h100);
    chk("redir_issue_rdy", 32'(s_rdy), 1);
    run(1, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("redir_r3_pc", s_pc, 32'h100);
    chk("redir_r3_vld", 32'(s_vld), 1);
    step(1'b0, '0, 1'b1);
    chk("redir_r4_pc", s_pc, 32'h104);
    run(3, 1'b1);

    // Misaligned target.
    step(1'b1, 32'h0000_0102, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("misalign_addr", s_addr, 32'h100);
    run(4, 1'b1);

    // Back-to-back redirects: nothing from the 0x200 stream may reach decode.
    bad200 = 0;
    step(1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 32'h0000_0300, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1);
      if (s_vld && s_pc[31:8] == 24'h2) bad200++;
      if (i == 2) chk("b2b_first_pc", s_pc, 32'h300);
    end
    chk("b2b_no_0x200", 32'(bad200), 0);

    // Slow ROM so a redirect must kill outstanding reads.
    lat = 3;
    run(8, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b1);
    run(12, 1'b1);

    // Random latency, backpressure and redirects.
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) step(1'b1, $urandom & 32'h0000_FFFF, 1'($urandom_range(0, 1)));
      else step(1'b0, '0, 1'($urandom_range(0, 1)));
    end

    // PC wrap at the top of the address space.
    lat = 1;
    run(6, 1'b1);
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("wrap_a0", s_addr, 32'hFFFF_FFF8);
    step(1'b0, '0, 1'b1);
    chk("wrap_a1", s_addr, 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b1);
    chk("wrap_a2", s_addr, 32'h0000_0000);
    run(4, 1'b1);

    // Reset mid-stream with reads pending; a stale response follows release.
    lat = 2;
    run(4, 1'b1);
    do_reset(1'b1);
    lat = 1;
    step(1'b0, '0, 1'b1);
    chk("rerun_c0_rdy", 32'(s_rdy), 1);
    chk("rerun_c0_addr", s_addr, RST_PC);
    run(1, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("rerun_c2_vld", 32'(s_vld), 1);
    chk("rerun_c2_pc", s_pc, RST_PC);
    run(6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
